// File: rtl/adsr_if.sv
// Signal bundle between the oscillator/control side and the ADSR amplitude stage.
// Control inputs are level-sampled every clock; there is no valid/ready handshake.
interface adsr_if;
    logic       gate;
    logic [7:0] sample_in;
    logic [7:0] attack_rate;
    logic [7:0] decay_rate;
    logic [7:0] sustain_level;
    logic [7:0] release_rate;
    logic [7:0] sample_out;
    logic [7:0] envelope;
    logic [2:0] env_state;

    modport master (
        output gate,
        output sample_in,
        output attack_rate,
        output decay_rate,
        output sustain_level,
        output release_rate,
        input  sample_out,
        input  envelope,
        input  env_state
    );

    modport slave (
        input  gate,
        input  sample_in,
        input  attack_rate,
        input  decay_rate,
        input  sustain_level,
        input  release_rate,
        output sample_out,
        output envelope,
        output env_state
    );
endinterface

// File: rtl/adsr_envelope.sv
// Gated ADSR envelope that scales an 8-bit unsigned oscillator sample about mid-scale 128.
// Optional macro ADSR_HARD_RESTART_EN: a retrigger from RELEASE restarts the attack from 0.
module adsr_envelope #(
    parameter int unsigned TICK_DIV = 256
) (
    input  logic   clk,
    input  logic   reset,
    adsr_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  env_q, env_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  out_q, out_d;
    logic        tick;
    logic        clear_cnt;

    logic signed [8:0]  centered;
    logic signed [16:0] product;
    logic signed [16:0] shifted;

    // Envelope arithmetic goes through a 9-bit intermediate so it can never wrap.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] floor_val);
        logic [8:0] diff;
        logic [7:0] result;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[8] || (diff[7:0] < floor_val)) begin
            result = floor_val;
        end else begin
            result = diff[7:0];
        end
        return result;
    endfunction

    assign tick = (cnt_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            env_q   <= 8'd0;
            cnt_q   <= 16'd0;
            out_q   <= 8'd128;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Gate decisions are checked before tick updates so a gate edge always wins.
    always_comb begin
        state_d   = state_q;
        env_d     = env_q;
        clear_cnt = 1'b0;
        case (state_q)
            IDLE: begin
                env_d = 8'd0;
                if (bus.gate) begin
                    state_d   = ATTACK;
                    clear_cnt = 1'b1;
                end
            end
            ATTACK: begin
                if (!bus.gate) begin
                    state_d = RELEASE;
                end else if (tick) begin
                    env_d = (bus.attack_rate == 8'd0) ? 8'hFF
                                                      : sat_add(env_q, bus.attack_rate);
                    if (env_d == 8'hFF) state_d = DECAY;
                end
            end
            DECAY: begin
                if (!bus.gate) begin
                    state_d = RELEASE;
                end else if (tick) begin
                    env_d = (bus.decay_rate == 8'd0) ? bus.sustain_level
                          : sat_sub(env_q, bus.decay_rate, bus.sustain_level);
                    if (env_d == bus.sustain_level) state_d = SUSTAIN;
                end
            end
            SUSTAIN: begin
                if (!bus.gate) begin
                    state_d = RELEASE;
                end else begin
                    env_d = bus.sustain_level;
                end
            end
            RELEASE: begin
                if (bus.gate) begin
                    state_d   = ATTACK;
                    clear_cnt = 1'b1;
`ifdef ADSR_HARD_RESTART_EN
                    env_d     = 8'd0;
`else
                    env_d     = env_q;
`endif
                end else if (tick) begin
                    env_d = (bus.release_rate == 8'd0) ? 8'd0
                          : sat_sub(env_q, bus.release_rate, 8'd0);
                    if (env_d == 8'd0) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                env_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clear_cnt || tick) cnt_d = 16'd0;
    end

    // Signed multiply about mid-scale; the shifted product stays within -128..126.
    assign centered = $signed({1'b0, bus.sample_in}) - 9'sd128;
    assign product  = 17'(centered) * 17'($signed({1'b0, env_q}));
    assign shifted  = product >>> 8;
    assign out_d    = shifted[7:0] + 8'd128;

    assign bus.sample_out = out_q;
    assign bus.envelope   = env_q;
    assign bus.env_state  = state_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope at TICK_DIV=4 with a queue-based scoreboard.
module tb_adsr_envelope;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q[$];

    adsr_if bus ();

    adsr_envelope #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [7:0] obs);
        logic [7:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0d expected=<empty queue>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    // Independent reference for the scaler: 128 + floor((s-128)*env/256).
    function automatic logic [7:0] scale_model(input int si, input int env);
        int p;
        int q;
        p = (si - 128) * env;
        if (p >= 0) q = p / 256;
        else        q = -((-p + 255) / 256);
        return 8'(128 + q);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        bus.gate          = 1'b1;
        bus.sample_in     = 8'd255;
        bus.attack_rate   = 8'd64;
        bus.decay_rate    = 8'd32;
        bus.sustain_level = 8'd100;
        bus.release_rate  = 8'd50;

        // Reset with gate held high
        step(2);
        check("reset_state", 8'(bus.env_state), 8'd0);
        check("reset_env", bus.envelope, 8'd0);
        check("reset_out", bus.sample_out, 8'd128);
        reset = 1'b0;
        step(1);
        check("attack_entry", 8'(bus.env_state), 8'd1);

        // Attack at rate 64, full-scale input
        exp_q.push_back(8'd64);
        exp_q.push_back(8'd128);
        exp_q.push_back(8'd192);
        exp_q.push_back(8'd255);
        for (int i = 0; i < 4; i++) begin
            step(4);
            check_pop("attack_env", bus.envelope);
        end
        check("decay_entry", 8'(bus.env_state), 8'd2);
        exp_q.push_back(scale_model(255, 255));
        step(1);
        check_pop("scale_max", bus.sample_out);
        bus.sample_in = 8'd0;
        exp_q.push_back(scale_model(0, 255));
        step(1);
        check_pop("scale_min", bus.sample_out);

        // Decay toward sustain 100
        exp_q.push_back(8'd223);
        step(2);
        check_pop("decay_env", bus.envelope);
        exp_q.push_back(8'd191);
        exp_q.push_back(8'd159);
        exp_q.push_back(8'd127);
        exp_q.push_back(8'd100);
        for (int i = 0; i < 4; i++) begin
            step(4);
            check_pop("decay_env", bus.envelope);
        end
        check("sustain_entry", 8'(bus.env_state), 8'd3);
        bus.sustain_level = 8'd90;
        step(1);
        check("sustain_track_90", bus.envelope, 8'd90);
        bus.sustain_level = 8'd100;
        step(1);
        check("sustain_track_100", bus.envelope, 8'd100);

        // Release at rate 50 down to idle
        bus.gate = 1'b0;
        step(1);
        check("release_entry", 8'(bus.env_state), 8'd4);
        check("release_hold", bus.envelope, 8'd100);
        step(1);
        check("release_env50", bus.envelope, 8'd50);
        step(4);
        check("release_env0", bus.envelope, 8'd0);
        check("idle_entry", 8'(bus.env_state), 8'd0);
        exp_q.push_back(scale_model(0, 0));
        step(1);
        check_pop("idle_out", bus.sample_out);

        // Zero rates: instantaneous attack and decay
        bus.attack_rate   = 8'd0;
        bus.decay_rate    = 8'd0;
        bus.sustain_level = 8'd200;
        bus.gate          = 1'b1;
        step(1);
        check("zr_attack_entry", 8'(bus.env_state), 8'd1);
        step(4);
        check("zr_attack_env", bus.envelope, 8'd255);
        check("zr_decay_state", 8'(bus.env_state), 8'd2);
        step(4);
        check("zr_decay_env", bus.envelope, 8'd200);
        check("zr_sustain_state", 8'(bus.env_state), 8'd3);

        // Retrigger from release at env 50
        bus.release_rate = 8'd150;
        bus.gate         = 1'b0;
        step(1);
        check("rt_release_entry", 8'(bus.env_state), 8'd4);
        step(3);
        check("rt_release_env", bus.envelope, 8'd50);
        bus.attack_rate = 8'd64;
        bus.gate        = 1'b1;
`ifdef ADSR_HARD_RESTART_EN
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd64);
        exp_q.push_back(8'd128);
`else
        exp_q.push_back(8'd50);
        exp_q.push_back(8'd114);
        exp_q.push_back(8'd178);
`endif
        step(1);
        check("rt_attack_entry", 8'(bus.env_state), 8'd1);
        check_pop("rt_start_env", bus.envelope);
        step(4);
        check_pop("rt_attack_env", bus.envelope);
        step(4);
        check_pop("rt_attack_env", bus.envelope);

        // Reset mid-note with gate high
        bus.sample_in = 8'd200;
        reset = 1'b1;
        step(1);
        check("midreset_state", 8'(bus.env_state), 8'd0);
        check("midreset_env", bus.envelope, 8'd0);
        check("midreset_out", bus.sample_out, 8'd128);
        reset = 1'b0;

        // Gate toggling every clock
        step(1);
        check("toggle_attack", 8'(bus.env_state), 8'd1);
        bus.gate = 1'b0;
        step(1);
        check("toggle_release", 8'(bus.env_state), 8'd4);
        bus.gate = 1'b1;
        step(1);
        check("toggle_reattack", 8'(bus.env_state), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
